// File: rtl/alu_pipe.sv
// Pipelined RV32I ALU/branch/jump execution unit between the reservation station and the ROB.
// Stage 0 computes the result; later stages only delay it, with per-stage bubble collapse.
module alu_pipe #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4,
    parameter int OP_W    = 6,
    parameter int LATENCY = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [XLEN-1:0]  in_vj,
    input  logic [XLEN-1:0]  in_vk,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_result,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(20);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(21);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(22);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(23);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(24);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(25);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(26);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(27);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(28);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(29);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(30);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(31);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(32);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(33);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(34);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(35);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(36);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(37);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             taken;
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  target;
    } entry_t;

    function automatic entry_t exec_op(input logic [OP_W-1:0] op, input logic [XLEN-1:0] vj,
                                       input logic [XLEN-1:0] vk, input logic [XLEN-1:0] imm,
                                       input logic [XLEN-1:0] pc, input logic [TAG_W-1:0] tag);
        entry_t          e;
        logic            is_br;
        logic [XLEN-1:0] jsum;
        logic [SHW-1:0]  sh_r;
        logic [SHW-1:0]  sh_i;
        e     = '0;
        e.tag = tag;
        is_br = 1'b0;
        jsum  = vj + imm;
        sh_r  = vk[SHW-1:0];
        sh_i  = imm[SHW-1:0];
        case (op)
            OP_LUI:   e.result = imm;
            OP_AUIPC: e.result = pc + imm;
            OP_JAL:   begin e.result = pc + XLEN'(4); e.taken = 1'b1; end
            OP_JALR:  begin
                e.result = pc + XLEN'(4);
                e.taken  = 1'b1;
                e.target = {jsum[XLEN-1:1], 1'b0};
            end
            OP_BEQ:   begin is_br = 1'b1; e.taken = (vj == vk); end
            OP_BNE:   begin is_br = 1'b1; e.taken = (vj != vk); end
            OP_BLT:   begin is_br = 1'b1; e.taken = ($signed(vj) < $signed(vk)); end
            OP_BGE:   begin is_br = 1'b1; e.taken = ($signed(vj) >= $signed(vk)); end
            OP_BLTU:  begin is_br = 1'b1; e.taken = (vj < vk); end
            OP_BGEU:  begin is_br = 1'b1; e.taken = (vj >= vk); end
            OP_ADDI:  e.result = vj + imm;
            OP_SLTI:  e.result = XLEN'($signed(vj) < $signed(imm));
            OP_SLTIU: e.result = XLEN'(vj < imm);
            OP_XORI:  e.result = vj ^ imm;
            OP_ORI:   e.result = vj | imm;
            OP_ANDI:  e.result = vj & imm;
            OP_SLLI:  e.result = vj << sh_i;
            OP_SRLI:  e.result = vj >> sh_i;
            OP_SRAI:  e.result = $unsigned($signed(vj) >>> sh_i);
            OP_ADD:   e.result = vj + vk;
            OP_SUB:   e.result = vj - vk;
            OP_SLL:   e.result = vj << sh_r;
            OP_SLT:   e.result = XLEN'($signed(vj) < $signed(vk));
            OP_SLTU:  e.result = XLEN'(vj < vk);
            OP_XOR:   e.result = vj ^ vk;
            OP_SRL:   e.result = vj >> sh_r;
            OP_SRA:   e.result = $unsigned($signed(vj) >>> sh_r);
            OP_OR:    e.result = vj | vk;
            OP_AND:   e.result = vj & vk;
            default:  e.result = '0;
        endcase
        if (is_br) begin
            e.result = pc + imm;
            e.target = pc + imm;
        end
        return e;
    endfunction

    logic [LATENCY-1:0] vld_p;
    logic [LATENCY-1:0] ld_p;
    entry_t             ent_p [LATENCY];
    entry_t             ent_in;
    logic               accept;

    // A stage may load iff the result port drains or some stage at or behind it is empty.
    always_comb begin
        logic full_tail;
        full_tail = 1'b1;
        ld_p      = '0;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            full_tail = full_tail & vld_p[k];
            ld_p[k]   = out_ready | !full_tail;
        end
    end

    assign in_ready = rdy_in & !rst_in & !flush_in & ld_p[0];
    assign accept   = in_valid & in_ready;
    assign ent_in   = exec_op(in_op, in_vj, in_vk, in_imm, in_pc, in_tag);

    // ---- stage 0 compute, stages 1..LATENCY-1 delay ----
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            vld_p <= '0;
        end else if (rdy_in) begin
            if (ld_p[0]) vld_p[0] <= accept && (in_op != OP_NOP);
            for (int k = 1; k < LATENCY; k++)
                if (ld_p[k]) vld_p[k] <= vld_p[k-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (ld_p[0]) ent_p[0] <= ent_in;
            for (int k = 1; k < LATENCY; k++)
                if (ld_p[k]) ent_p[k] <= ent_p[k-1];
        end
    end

    // ---- output stage ----
    assign out_valid  = vld_p[LATENCY-1];
    assign out_tag    = out_valid ? ent_p[LATENCY-1].tag    : '0;
    assign out_result = out_valid ? ent_p[LATENCY-1].result : '0;
    assign out_taken  = out_valid ? ent_p[LATENCY-1].taken  : 1'b0;
    assign out_target = out_valid ? ent_p[LATENCY-1].target : '0;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (LATENCY=2): ops, back-pressure, flush, reset and freeze.
module tb_alu_pipe;

    localparam logic [5:0] NOP = 6'd0,  LUI = 6'd1,  AUIPC = 6'd2, JAL = 6'd3, JALR = 6'd4;
    localparam logic [5:0] BEQ = 6'd5,  BLT = 6'd7,  BGEU = 6'd10;
    localparam logic [5:0] SRLI = 6'd26, XORI = 6'd22;
    localparam logic [5:0] ADD = 6'd28, SUB = 6'd29, SLL = 6'd30, SLT = 6'd31, SLTU = 6'd32;
    localparam logic [5:0] SRA = 6'd35, UNDEF = 6'd63;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, in_valid, in_ready, flush_in;
    logic [5:0]  in_op;
    logic [31:0] in_vj, in_vk, in_imm, in_pc;
    logic [3:0]  in_tag;
    logic        out_valid, out_ready, out_taken;
    logic [3:0]  out_tag;
    logic [31:0] out_result, out_target;

    int n_checks = 0;
    int n_errors = 0;

    alu_pipe #(.XLEN(32), .TAG_W(4), .OP_W(6), .LATENCY(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_vj(in_vj), .in_vk(in_vk), .in_imm(in_imm), .in_pc(in_pc), .in_tag(in_tag),
        .flush_in(flush_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_result(out_result), .out_taken(out_taken), .out_target(out_target)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_op = NOP; in_vj = '0; in_vk = '0; in_imm = '0; in_pc = '0; in_tag = '0;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
        in_valid = 1'b1; in_op = op; in_vj = vj; in_vk = vk; in_imm = imm; in_pc = pc; in_tag = tag;
    endtask

    // Issue one op into an empty pipe, check it two cycles later, then let it drain.
    task automatic exec_check(input string name, input logic [5:0] op, input logic [31:0] vj,
                              input logic [31:0] vk, input logic [31:0] imm, input logic [31:0] pc,
                              input logic [3:0] tag, input logic [31:0] e_res, input logic e_taken,
                              input logic [31:0] e_tgt);
        drive(op, vj, vk, imm, pc, tag);
        #1;
        check({name, ".in_ready"}, in_ready, 1);
        tick();
        idle();
        check({name, ".early_valid"}, out_valid, 0);
        tick();
        check({name, ".valid"}, out_valid, 1);
        check({name, ".tag"}, out_tag, tag);
        check({name, ".result"}, out_result, e_res);
        check({name, ".taken"}, out_taken, e_taken);
        check({name, ".target"}, out_target, e_tgt);
        tick();
        check({name, ".drained"}, out_valid, 0);
    endtask

    initial begin
        int nxt_in;
        int nxt_out;
        int seen;
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; out_ready = 1'b1;
        idle();
        tick();
        tick();
        in_valid = 1'b1; in_op = ADD; in_tag = 4'd1;
        #1;
        check("rst.in_ready", in_ready, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.out_tag", out_tag, 0);
        check("rst.out_result", out_result, 0);
        check("rst.out_target", out_target, 0);
        idle();
        rst_in = 1'b0;
        tick();

        // Directed op table
        exec_check("add",   ADD,   32'd5,          32'd7,          32'd0,          32'd0,     4'd3, 32'd12,         0, 32'd0);
        exec_check("sub",   SUB,   32'd5,          32'd7,          32'd0,          32'd0,     4'd2, 32'hFFFF_FFFE,  0, 32'd0);
        exec_check("sra",   SRA,   32'h8000_0000,  32'd33,         32'd0,          32'd0,     4'd4, 32'hC000_0000,  0, 32'd0);
        exec_check("sltu",  SLTU,  32'd1,          32'hFFFF_FFFF,  32'd0,          32'd0,     4'd5, 32'd1,          0, 32'd0);
        exec_check("slt",   SLT,   32'd1,          32'hFFFF_FFFF,  32'd0,          32'd0,     4'd6, 32'd0,          0, 32'd0);
        exec_check("sll",   SLL,   32'd1,          32'd36,         32'd0,          32'd0,     4'd7, 32'd16,         0, 32'd0);
        exec_check("srli",  SRLI,  32'h8000_0000,  32'd0,          32'd31,         32'd0,     4'd8, 32'd1,          0, 32'd0);
        exec_check("xori",  XORI,  32'h0000_F0F0,  32'd0,          32'hFFFF_FFFF,  32'd0,     4'd9, 32'hFFFF_0F0F,  0, 32'd0);
        exec_check("lui",   LUI,   32'd0,          32'd0,          32'h1234_5000,  32'd0,     4'd10, 32'h1234_5000, 0, 32'd0);
        exec_check("auipc", AUIPC, 32'd0,          32'd0,          32'h2000,       32'h1000,  4'd11, 32'h3000,      0, 32'd0);
        exec_check("blt",   BLT,   32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFF8,  32'h100,   4'd12, 32'hF8,        1, 32'hF8);
        exec_check("bgeu",  BGEU,  32'd1,          32'hFFFF_FFFF,  32'h20,         32'h100,   4'd13, 32'h120,       0, 32'h120);
        exec_check("beq",   BEQ,   32'd3,          32'd3,          32'd4,          32'd0,     4'd14, 32'd4,         1, 32'd4);
        exec_check("jal",   JAL,   32'd0,          32'd0,          32'h100,        32'h40,    4'd15, 32'h44,        1, 32'd0);
        exec_check("jalr",  JALR,  32'h1001,       32'd0,          32'd2,          32'h40,    4'd1, 32'h44,         1, 32'h1002);
        exec_check("undef", UNDEF, 32'd9,          32'd9,          32'd9,          32'd9,     4'd5, 32'd0,          0, 32'd0);

        // NOP is consumed without producing an output
        drive(NOP, 32'd1, 32'd1, 32'd0, 32'd0, 4'd6);
        #1;
        check("nop.in_ready", in_ready, 1);
        tick();
        idle();
        tick();
        check("nop.no_out", out_valid, 0);
        tick();
        check("nop.no_out2", out_valid, 0);

        // Back-pressure: only LATENCY ops buffered, then release in order
        out_ready = 1'b0;
        drive(ADD, 32'd1, 32'd10, 32'd0, 32'd0, 4'd1);
        #1;
        check("bp.acc1", in_ready, 1);
        tick();
        drive(ADD, 32'd2, 32'd10, 32'd0, 32'd0, 4'd2);
        #1;
        check("bp.acc2", in_ready, 1);
        tick();
        drive(ADD, 32'd3, 32'd10, 32'd0, 32'd0, 4'd3);
        #1;
        check("bp.full", in_ready, 0);
        tick();
        check("bp.full2", in_ready, 0);
        check("bp.hold_valid", out_valid, 1);
        check("bp.hold_tag", out_tag, 1);
        check("bp.hold_result", out_result, 11);
        out_ready = 1'b1;
        nxt_in = 3;
        nxt_out = 1;
        for (int cyc = 0; cyc < 20 && nxt_out <= 4; cyc++) begin
            if (nxt_in <= 4) drive(ADD, 32'(nxt_in), 32'd10, 32'd0, 32'd0, 4'(nxt_in));
            else idle();
            #1;
            if (out_valid) begin
                check("bp.order_tag", out_tag, 64'(nxt_out));
                check("bp.order_result", out_result, 64'(nxt_out + 10));
                nxt_out++;
            end
            if (in_valid && in_ready) nxt_in++;
            tick();
        end
        idle();
        check("bp.all_out", 64'(nxt_out), 5);
        tick();
        check("bp.empty", out_valid, 0);

        // Flush with two ops in flight and a request in the same cycle
        out_ready = 1'b0;
        drive(ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd7);
        tick();
        drive(ADD, 32'd2, 32'd2, 32'd0, 32'd0, 4'd8);
        tick();
        drive(ADD, 32'd3, 32'd3, 32'd0, 32'd0, 4'd9);
        flush_in = 1'b1;
        #1;
        check("flush.in_ready", in_ready, 0);
        tick();
        flush_in = 1'b0;
        out_ready = 1'b1;
        idle();
        check("flush.out_valid", out_valid, 0);
        check("flush.out_tag", out_tag, 0);
        seen = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (out_valid) seen++;
            tick();
        end
        check("flush.never_emitted", 64'(seen), 0);

        // Reset mid-stream
        drive(ADD, 32'd4, 32'd4, 32'd0, 32'd0, 4'd10);
        tick();
        drive(ADD, 32'd5, 32'd5, 32'd0, 32'd0, 4'd11);
        tick();
        check("midrst.pre_valid", out_valid, 1);
        rst_in = 1'b1;
        #1;
        check("midrst.in_ready", in_ready, 0);
        tick();
        rst_in = 1'b0;
        idle();
        check("midrst.out_valid", out_valid, 0);
        check("midrst.out_tag", out_tag, 0);
        check("midrst.out_result", out_result, 0);
        check("midrst.out_taken", out_taken, 0);
        check("midrst.out_target", out_target, 0);
        tick();
        check("midrst.stays_empty", out_valid, 0);

        // rdy_in low freezes everything
        out_ready = 1'b0;
        drive(ADD, 32'd1, 32'd2, 32'd0, 32'd0, 4'd12);
        tick();
        idle();
        tick();
        check("frz.pre_valid", out_valid, 1);
        rdy_in = 1'b0;
        out_ready = 1'b1;
        drive(ADD, 32'd7, 32'd7, 32'd0, 32'd0, 4'd13);
        for (int cyc = 0; cyc < 3; cyc++) begin
            #1;
            check("frz.in_ready", in_ready, 0);
            tick();
            check("frz.valid", out_valid, 1);
            check("frz.tag", out_tag, 12);
            check("frz.result", out_result, 3);
        end
        rdy_in = 1'b1;
        idle();
        tick();
        check("frz.drained", out_valid, 0);
        tick();
        check("frz.no_accept", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
